// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the imem request/ack handshake and holds the instruction register.
// Optional build macro IFETCH_PERF_EN adds saturating fetch/stall performance counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam int unsigned TW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic [31:0]   pc_nxt;
    logic [31:0]   instr_nxt;
    logic          valid_nxt;
    logic          err_nxt;
    logic          req_nxt;
    logic [31:0]   next_pc;
    logic          fetch_active;
    logic          got_ack;
    logic          timed_out;
    logic          consume;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[31:26];

    // The request is only live once imem_req is up; the first post-reset cycle neither counts nor accepts acks.
    assign fetch_active = (state == S_FETCH) && imem_req;
    assign got_ack      = fetch_active && imem_ack;
    assign timed_out    = (TIMEOUT != 0) && fetch_active && !imem_ack && (tcnt == TW'(TIMEOUT - 1));
    assign consume      = (state == S_ISSUE) && !stall;

    // Jump outranks a taken branch; both targets are forced word-aligned.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = (pc_plus4 & 32'hF000_0000) | {4'b0000, instr[25:0], 2'b00};
        end else if (pcsrc) begin
            next_pc = branch_target & 32'hFFFF_FFFC;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (got_ack) begin
                    state_nxt = S_ISSUE;
                end else if (timed_out) begin
                    state_nxt = S_HALT;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        pc_nxt    = pc;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        err_nxt   = fetch_err;
        tcnt_nxt  = tcnt;
        req_nxt   = (state_nxt == S_FETCH);
        case (state)
            S_FETCH: begin
                if (got_ack) begin
                    instr_nxt = imem_rdata;
                    valid_nxt = 1'b1;
                end else if (fetch_active && (TIMEOUT != 0)) begin
                    tcnt_nxt = tcnt + TW'(1);
                    if (timed_out) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (consume) begin
                    pc_nxt    = next_pc;
                    valid_nxt = 1'b0;
                    tcnt_nxt  = '0;
                end
            end
            S_HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            tcnt        <= '0;
            imem_req    <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fetch_err   <= err_nxt;
            tcnt        <= tcnt_nxt;
            imem_req    <= req_nxt;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] fcnt;
    logic [31:0] scnt;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= 32'h0;
            scnt <= 32'h0;
        end else begin
            if (consume && (fcnt != 32'hFFFF_FFFF)) begin
                fcnt <= fcnt + 32'd1;
            end
            if ((state == S_ISSUE) && stall && (scnt != 32'hFFFF_FFFF)) begin
                scnt <= scnt + 32'd1;
            end
        end
    end

    assign fetch_count = fcnt;
    assign stall_count = scnt;
`else
    assign fetch_count = 32'h0;
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level PC/instruction model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pcsrc;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    int          exp_fetch;
    int          exp_stall;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .pcsrc(pcsrc), .jump(jump), .branch_target(branch_target),
        .instr(instr), .op(op), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_err(fetch_err),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic perf_check();
`ifdef IFETCH_PERF_EN
        check("fetch_count", fetch_count, 32'(exp_fetch));
        check("stall_count", stall_count, 32'(exp_stall));
`else
        check("fetch_count_tied", fetch_count, 32'h0);
        check("stall_count_tied", stall_count, 32'h0);
`endif
    endtask

    // One instruction: ack after 'delay' idle cycles, stall 'nstall' cycles, consume with j/b/bt.
    task automatic run_instr(input int delay, input int nstall, input logic [31:0] data,
                             input logic j, input logic b, input logic [31:0] bt);
        logic [31:0] nxt;
        check("req_fetch", imem_req, 1'b1);
        check("addr_fetch", imem_addr, exp_pc);
        check("valid_fetch", instr_valid, 1'b0);
        for (int d = 0; d < delay; d++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            stall      = 1'($urandom);
            step();
            check("req_held", imem_req, 1'b1);
            check("pc_wait", pc, exp_pc);
            check("err_wait", fetch_err, 1'b0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack = 1'b0;
        check("valid_issue", instr_valid, 1'b1);
        check("instr", instr, data);
        check("op", 32'(op), 32'(data[31:26]));
        check("pc_issue", pc, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        check("req_issue", imem_req, 1'b0);
        for (int s = 0; s < nstall; s++) begin
            stall         = 1'b1;
            pcsrc         = 1'($urandom);
            jump          = 1'($urandom);
            branch_target = $urandom;
            imem_ack      = 1'($urandom);
            imem_rdata    = $urandom;
            step();
            exp_stall++;
            check("instr_stall", instr, data);
            check("pc_stall", pc, exp_pc);
            check("valid_stall", instr_valid, 1'b1);
            check("req_stall", imem_req, 1'b0);
        end
        imem_ack      = 1'b0;
        stall         = 1'b0;
        jump          = j;
        pcsrc         = b;
        branch_target = bt;
        step();
        if (j) begin
            nxt = ((exp_pc + 32'd4) & 32'hF000_0000) | ((data & 32'h03FF_FFFF) << 2);
        end else if (b) begin
            nxt = bt & ~32'h3;
        end else begin
            nxt = exp_pc + 32'd4;
        end
        exp_pc = nxt;
        exp_fetch++;
        jump          = 1'($urandom);
        pcsrc         = 1'($urandom);
        branch_target = $urandom;
        check("pc_next", pc, exp_pc);
        check("valid_consumed", instr_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        pcsrc = 1'b0; jump = 1'b0; branch_target = 32'h0;
        exp_pc = 32'h0; exp_fetch = 0; exp_stall = 0;
        step();
        step();
        check("rst_req", imem_req, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        perf_check();
        rst = 1'b0;
        step();
        check("req_after_rst", imem_req, 1'b1);

        // Back-to-back nops: 0 -> 4 -> 8 -> C
        for (int i = 0; i < 3; i++) run_instr(0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("seq_pc_c", pc, 32'h0000_000C);
        run_instr(3, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        run_instr(0, 4, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0400);
        perf_check();

        // Jump beats branch
        run_instr(0, 0, 32'h0, 1'b0, 1'b1, 32'h0000_1000);
        run_instr(0, 0, 32'h0800_0040, 1'b1, 1'b1, 32'h0000_2000);
        check("jump_wins", pc, 32'h0000_0100);

        // PC wrap
        run_instr(1, 0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run_instr(0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("pc_wrap", pc, 32'h0);

        for (int i = 0; i < 150; i++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[31:26] = 6'b000010;
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), d,
                      1'($urandom), 1'($urandom), $urandom);
        end
        perf_check();

        // Timeout
        imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            check("err_pre_timeout", fetch_err, 1'b0);
            check("req_pre_timeout", imem_req, 1'b1);
        end
        step();
        check("err_timeout", fetch_err, 1'b1);
        check("req_halt", imem_req, 1'b0);
        check("valid_halt", instr_valid, 1'b0);
        check("pc_halt", pc, exp_pc);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            stall    = 1'($urandom);
            step();
            check("err_sticky", fetch_err, 1'b1);
            check("req_halt_ack", imem_req, 1'b0);
            check("valid_halt_ack", instr_valid, 1'b0);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        rst = 1'b1;
        step();
        check("rst2_pc", pc, 32'h0);
        check("rst2_err", fetch_err, 1'b0);
        check("rst2_req", imem_req, 1'b0);
        exp_pc = 32'h0; exp_fetch = 0; exp_stall = 0;
        perf_check();
        rst = 1'b0;
        step();
        check("req_after_rst2", imem_req, 1'b1);

        // Reset abandons an outstanding request
        run_instr(0, 2, 32'hCAFE_0001, 1'b0, 1'b1, 32'h0000_0800);
        step();
        check("req_mid_fetch", imem_req, 1'b1);
        rst = 1'b1;
        step();
        check("req_rst_mid_fetch", imem_req, 1'b0);
        check("pc_rst_mid_fetch", pc, 32'h0);
        rst = 1'b0;
        exp_pc = 32'h0; exp_fetch = 0; exp_stall = 0;
        step();
        run_instr(1, 1, 32'hABCD_0123, 1'b0, 1'b0, 32'h0);
        perf_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
